traffic_phase_ctrl: RTL

Parametrised N-road signal-phase controller, the successor to the fixed four-board timer/encoder/decoder signal path. It sequences one road at a time through GREEN, AMBER and optional ALL_RED phases using a single down-counter. The next road is chosen by emergency request, then priority request, then round-robin. It drives a 5-bit lamp word per road and a phase countdown for the 7-segment display path.

---
 rtl/traffic_phase_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/traffic_phase_ctrl.sv
// N-road signal-phase controller: GREEN -> AMBER [-> ALL_RED] -> GREEN of the next road.
// Optional ALL_RED phase is compiled in with `define TRAFFIC_ALLRED_EN.
module traffic_phase_ctrl #(
   parameter int NUM_ROADS     = 4,
   parameter int GREEN_CYCLES  = 16,
   parameter int AMBER_CYCLES  = 4,
   parameter int ALLRED_CYCLES = 2,
   parameter int CNT_W         = 6,
   localparam int ROAD_W       = (NUM_ROADS > 2) ? $clog2(NUM_ROADS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_ROADS-1:0]   prio_req,
   input  logic [NUM_ROADS-1:0]   emer_req,
   output logic [5*NUM_ROADS-1:0] light_out,
   output logic [ROAD_W-1:0]      active_road,
   output logic [CNT_W-1:0]       countdown,
   output logic                   phase_done,
   output logic                   preempted
);

`ifdef TRAFFIC_ALLRED_EN
   typedef enum logic [1:0] {GREEN, AMBER, ALL_RED} state_t;
`else
   typedef enum logic {GREEN, AMBER} state_t;
`endif

   if (NUM_ROADS < 2 || NUM_ROADS > 16 || GREEN_CYCLES < 1 || AMBER_CYCLES < 1 ||
       ALLRED_CYCLES < 1) begin : g_bad_cfg
      $error("traffic_phase_ctrl: illegal parameter set");
   end

   state_t             state_q, state_d;
   logic [ROAD_W-1:0]  road_q, road_d, sel_road;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pd_q, pd_d, pre_q, pre_d;
   logic [NUM_ROADS-1:0] road_oh;
   logic               emer_own, emer_other, go_green;
   logic               found_p, found_e;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= GREEN;
         road_q  <= '0;
         cnt_q   <= CNT_W'(GREEN_CYCLES - 1);
         pd_q    <= 1'b0;
         pre_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         road_q  <= road_d;
         cnt_q   <= cnt_d;
         pd_q    <= pd_d;
         pre_q   <= pre_d;
      end
   end

   // Next road: lowest emergency, else lowest priority other than the current road, else round-robin.
   always_comb begin
      road_oh    = NUM_ROADS'(1) << road_q;
      emer_own   = |(emer_req & road_oh);
      emer_other = |(emer_req & ~road_oh);
      found_p    = 1'b0;
      found_e    = 1'b0;
      sel_road   = (road_q == ROAD_W'(NUM_ROADS - 1)) ? '0 : road_q + 1'b1;
      for (int unsigned i = 0; i < NUM_ROADS; i++) begin
         if (!found_p && prio_req[i] && ROAD_W'(i) != road_q) begin
            found_p  = 1'b1;
            sel_road = ROAD_W'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_ROADS; i++) begin
         if (!found_e && emer_req[i]) begin
            found_e  = 1'b1;
            sel_road = ROAD_W'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      road_d   = road_q;
      cnt_d    = cnt_q;
      pd_d     = 1'b0;
      pre_d    = pre_q;
      go_green = 1'b0;
      case (state_q)
         GREEN: begin
            if (emer_other) begin
               state_d = AMBER;
               cnt_d   = CNT_W'(AMBER_CYCLES - 1);
               pre_d   = 1'b1;
            end else if (emer_own) begin
               cnt_d = cnt_q;
            end else if (cnt_q == '0) begin
               state_d = AMBER;
               cnt_d   = CNT_W'(AMBER_CYCLES - 1);
               pre_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         AMBER: begin
            if (cnt_q == '0) begin
`ifdef TRAFFIC_ALLRED_EN
               state_d = ALL_RED;
               cnt_d   = CNT_W'(ALLRED_CYCLES - 1);
               pre_d   = 1'b0;
`else
               go_green = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef TRAFFIC_ALLRED_EN
         ALL_RED: begin
            if (cnt_q == '0) go_green = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
         end
`endif
         default: state_d = GREEN;
      endcase
      if (go_green) begin
         state_d = GREEN;
         road_d  = sel_road;
         cnt_d   = CNT_W'(GREEN_CYCLES - 1);
         pd_d    = 1'b1;
         pre_d   = 1'b0;
      end
   end

   always_comb begin
      light_out = '0;
      for (int unsigned k = 0; k < NUM_ROADS; k++) begin
         if (ROAD_W'(k) == road_q)
            light_out[5*k +: 5] = (state_q == GREEN) ? 5'b00111 : 5'b01000;
         else
            light_out[5*k +: 5] = 5'b10100;
      end
`ifdef TRAFFIC_ALLRED_EN
      if (state_q == ALL_RED) light_out = {NUM_ROADS{5'b10000}};
`endif
   end

   assign active_road = road_q;
   assign countdown   = cnt_q;
   assign phase_done  = pd_q;
   assign preempted   = pre_q;

endmodule
